seg7_scan_mux: RTL and testbench

Time-multiplexed driver for an N-digit common-anode 7-segment display. It latches a packed BCD/symbol word with per-digit decimal points and applies it tear-free at frame boundaries. It scans the digits with a programmable dwell time and an anti-ghosting dead time, and suppresses leading zeros. It sits between the temperature formatting logic and the board display pins.

---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/seg7_lz_mask.sv | 37 +++
 rtl/seg7_scan_mux.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_mux.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver.
// Holds the display code constants, the blank segment pattern, the scan
// phase enum and the code-to-segment encoder ({g,f,e,d,c,b,a}, active-low).
package seg7_pkg;

    localparam int unsigned CODE_W = 4;
    localparam int unsigned SEG_W  = 7;

    localparam logic [CODE_W-1:0] CODE_MINUS = 4'd10;
    localparam logic [CODE_W-1:0] CODE_BLANK = 4'd15;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_SHOW = 1'b1
    } scan_state_t;

    // Active-low segment pattern for a display code; 11..15 render blank.
    function automatic logic [SEG_W-1:0] seg7_encode(input logic [CODE_W-1:0] code);
        logic [SEG_W-1:0] pat;
        pat = SEG_OFF;
        case (code)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            4'd10:   pat = 7'b0111111;
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// Leading-zero blanking mask for the committed display word.
// Ports:
//   codes   - packed display codes, digit i at [4i+3:4i]
//   dps     - per-digit decimal point (1 = lit)
//   blank_c - per-digit blank request (combinational), digit 0 never set
module seg7_lz_mask
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned LZ_SUPPRESS = 1
) (
    input  logic [CODE_W*NUM_DIGITS-1:0] codes,
    input  logic [NUM_DIGITS-1:0]        dps,
    output logic [NUM_DIGITS-1:0]        blank_c
);

    logic              run;
    logic [CODE_W-1:0] code;

    // Walk from the most significant digit down; the first digit that is
    // nonzero, a minus, or carries a lit dp ends the run. Blank codes are
    // treated like zeros so a pre-blanked field keeps suppressing.
    always_comb begin
        blank_c = '0;
        code    = '0;
        run     = (LZ_SUPPRESS != 0);
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            code = codes[CODE_W*i +: CODE_W];
            if (run && !dps[i] && (code == 4'd0 || code > CODE_MINUS)) begin
                blank_c[i] = 1'b1;
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// A load strobe fills a shadow register; the shadow is committed to the
// display register only at frame boundaries so a frame never tears. Each
// digit slot is SCAN_DIV cycles: DEAD_CYCLES all-off, then the digit shows.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   digits_in  - packed 4-bit codes, digit 0 rightmost
//   dp_in      - per-digit decimal point, 1 = lit
//   load       - one-cycle capture strobe into the shadow register
//   seg, dp    - active-low segments {g,f,e,d,c,b,a} and decimal point
//   an         - active-low anodes, one-hot-low while showing
//   frame_tick - one-cycle pulse after a display commit
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned DEAD_CYCLES = 500,
    parameter int unsigned LZ_SUPPRESS = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CODE_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]        dp_in,
    input  logic                         load,
    output logic [SEG_W-1:0]             seg,
    output logic                         dp,
    output logic [NUM_DIGITS-1:0]        an,
    output logic                         frame_tick
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned WORD_W = CODE_W * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic             HAS_DEAD = (DEAD_CYCLES != 0);
    localparam scan_state_t      ST_RESET = HAS_DEAD ? ST_DEAD : ST_SHOW;
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    // Scan sequencing state
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [IDX_W-1:0] idx, idx_next;
    scan_state_t      state, state_next;
    logic             first;
    logic             slot_end;
    logic             commit;

    // Frame data
    logic [WORD_W-1:0]     shadow_code;
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [WORD_W-1:0]     disp_code;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic [CODE_W-1:0]     disp_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blank_mask;

    // Next output values
    logic [SEG_W-1:0]      seg_d;
    logic                  dp_d;
    logic [NUM_DIGITS-1:0] an_d;

    // State register: slot counter, digit index, phase, post-reset commit flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            idx   <= '0;
            state <= ST_RESET;
            first <= 1'b1;
        end else begin
            cnt   <= cnt_next;
            idx   <= idx_next;
            state <= state_next;
            first <= 1'b0;
        end
    end

    // Next-state: the phase register tracks the phase of the next count
    always_comb begin
        slot_end   = (cnt == CNT_LAST);
        cnt_next   = slot_end ? '0 : cnt + CNT_W'(1);
        idx_next   = idx;
        if (slot_end) begin
            idx_next = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
        state_next = (HAS_DEAD && cnt_next < DEAD_LIM) ? ST_DEAD : ST_SHOW;
        commit     = first | (slot_end & (idx == IDX_LAST));
    end

    // Shadow capture and frame commit; a load on the commit edge bypasses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_code <= {NUM_DIGITS{CODE_BLANK}};
            shadow_dp   <= '0;
            disp_code   <= {NUM_DIGITS{CODE_BLANK}};
            disp_dp     <= '0;
        end else begin
            if (load) begin
                shadow_code <= digits_in;
                shadow_dp   <= dp_in;
            end
            if (commit) begin
                disp_code <= load ? digits_in : shadow_code;
                disp_dp   <= load ? dp_in     : shadow_dp;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            disp_arr[i] = disp_code[CODE_W*i +: CODE_W];
        end
    end

    seg7_lz_mask #(
        .NUM_DIGITS  (NUM_DIGITS),
        .LZ_SUPPRESS (LZ_SUPPRESS)
    ) u_lz_mask (
        .codes   (disp_code),
        .dps     (disp_dp),
        .blank_c (blank_mask)
    );

    // Output decode from the current phase and digit
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state == ST_SHOW) begin
            an_d  = ~(AN_ONE << idx);
            seg_d = blank_mask[idx] ? SEG_OFF : seg7_encode(disp_arr[idx]);
            dp_d  = ~disp_dp[idx];
        end
    end

    // Pin registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_d;
            dp         <= dp_d;
            an         <= an_d;
            frame_tick <= commit;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux: NUM_DIGITS=4, SCAN_DIV=8, DEAD_CYCLES=2.
// dut_a has leading-zero blanking enabled, dut_b has it disabled; both share
// the same stimulus.
module tb_seg7_scan_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  dp_in = 4'h0;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [3:0] an_a, an_b;
    logic       tick_a, tick_b;

    int total = 0;
    int bad   = 0;

    // Per-frame capture results
    logic [6:0] cap_seg_a [4];
    logic [6:0] cap_seg_b [4];
    logic       cap_dp_a  [4];
    int         cap_shows [4];
    int         cap_bad_an;
    int         cap_wait;
    bit         cap_ok;

    always #5 clk = ~clk;

    seg7_scan_mux #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .DEAD_CYCLES(2), .LZ_SUPPRESS(1)
    ) dut_a (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .seg(seg_a), .dp(dp_a), .an(an_a), .frame_tick(tick_a)
    );

    seg7_scan_mux #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .DEAD_CYCLES(2), .LZ_SUPPRESS(0)
    ) dut_b (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .seg(seg_b), .dp(dp_b), .an(an_b), .frame_tick(tick_b)
    );

    // Step negedges until frame_tick is seen (bounded); drops load each step
    task automatic wait_tick(output bit ok, output int waits);
        ok = 1'b0;
        waits = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            load = 1'b0;
            waits++;
            if (tick_a === 1'b1) ok = 1'b1;
        end
    endtask

    // Record what each digit shows over the frame following the next tick
    task automatic capture();
        logic [3:0] sel;
        wait_tick(cap_ok, cap_wait);
        cap_bad_an = 0;
        for (int d = 0; d < 4; d++) begin
            cap_seg_a[d] = 7'h00;
            cap_seg_b[d] = 7'h00;
            cap_dp_a[d]  = 1'b0;
            cap_shows[d] = 0;
        end
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            load = 1'b0;
            for (int d = 0; d < 4; d++) begin
                sel = 4'hF;
                sel[d] = 1'b0;
                if (an_a === sel) begin
                    cap_seg_a[d] = seg_a;
                    cap_dp_a[d]  = dp_a;
                    cap_shows[d]++;
                end
                if (an_b === sel) cap_seg_b[d] = seg_b;
            end
            if (an_a !== 4'hF && $countones(~an_a) != 1) cap_bad_an++;
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        @(negedge clk);
        total++; if (seg_a !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h exp=7f", seg_a); end
        total++; if (an_a !== 4'hF) begin bad++; $display("FAIL reset_an got=%h exp=f", an_a); end
        total++; if (dp_a !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b exp=1", dp_a); end
        total++; if (tick_a !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", tick_a); end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_an = (k <= 2) ? 4'hF : 4'hE;
            total++;
            if (an_a !== exp_an) begin bad++; $display("FAIL release_an[%0d] got=%h exp=%h", k, an_a, exp_an); end
            if (k == 1) begin
                total++;
                if (tick_a !== 1'b1) begin bad++; $display("FAIL first_commit_tick got=%b exp=1", tick_a); end
            end
        end
    endtask

    task automatic test_basic();
        logic [6:0] ea [4] = '{7'h30, 7'h24, 7'h79, 7'h7F};
        logic [6:0] eb [4] = '{7'h30, 7'h24, 7'h79, 7'h40};
        digits_in = 16'h0123; dp_in = 4'b0000; load = 1'b1;
        capture();
        total++; if (!cap_ok) begin bad++; $display("FAIL basic_tick got=timeout exp=tick"); end
        total++; if (cap_bad_an != 0) begin bad++; $display("FAIL basic_an_onehot got=%0d exp=0", cap_bad_an); end
        total++; if (cap_shows[0] != 6) begin bad++; $display("FAIL basic_show_len got=%0d exp=6", cap_shows[0]); end
        for (int d = 0; d < 4; d++) begin
            total++; if (cap_seg_a[d] !== ea[d]) begin bad++; $display("FAIL basic_seg_a[%0d] got=%h exp=%h", d, cap_seg_a[d], ea[d]); end
            total++; if (cap_seg_b[d] !== eb[d]) begin bad++; $display("FAIL basic_seg_b[%0d] got=%h exp=%h", d, cap_seg_b[d], eb[d]); end
            total++; if (cap_dp_a[d] !== 1'b1) begin bad++; $display("FAIL basic_dp[%0d] got=%b exp=1", d, cap_dp_a[d]); end
        end
    endtask

    task automatic test_dp_zero();
        logic [6:0] ea [4] = '{7'h12, 7'h40, 7'h7F, 7'h7F};
        logic [6:0] eb [4] = '{7'h12, 7'h40, 7'h40, 7'h40};
        logic       ed [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        digits_in = 16'h0005; dp_in = 4'b0010; load = 1'b1;
        capture();
        total++; if (!cap_ok) begin bad++; $display("FAIL dpz_tick got=timeout exp=tick"); end
        for (int d = 0; d < 4; d++) begin
            total++; if (cap_seg_a[d] !== ea[d]) begin bad++; $display("FAIL dpz_seg_a[%0d] got=%h exp=%h", d, cap_seg_a[d], ea[d]); end
            total++; if (cap_seg_b[d] !== eb[d]) begin bad++; $display("FAIL dpz_seg_b[%0d] got=%h exp=%h", d, cap_seg_b[d], eb[d]); end
            total++; if (cap_dp_a[d] !== ed[d]) begin bad++; $display("FAIL dpz_dp[%0d] got=%b exp=%b", d, cap_dp_a[d], ed[d]); end
        end
    endtask

    task automatic test_minus();
        logic [6:0] ea [4] = '{7'h12, 7'h24, 7'h40, 7'h3F};
        digits_in = 16'hA025; dp_in = 4'b0000; load = 1'b1;
        capture();
        total++; if (!cap_ok) begin bad++; $display("FAIL minus_tick got=timeout exp=tick"); end
        for (int d = 0; d < 4; d++) begin
            total++; if (cap_seg_a[d] !== ea[d]) begin bad++; $display("FAIL minus_seg_a[%0d] got=%h exp=%h", d, cap_seg_a[d], ea[d]); end
            total++; if (cap_seg_b[d] !== ea[d]) begin bad++; $display("FAIL minus_seg_b[%0d] got=%h exp=%h", d, cap_seg_b[d], ea[d]); end
        end
    endtask

    // Display holds A025; load 0123 while digit 2 is on
    task automatic test_midframe_load();
        logic [6:0] ea [4] = '{7'h30, 7'h24, 7'h79, 7'h7F};
        bit ok;
        int w;
        wait_tick(ok, w);
        total++; if (!ok) begin bad++; $display("FAIL mid_tick got=timeout exp=tick"); end
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            load = (k == 19);
            if (k == 19) begin
                digits_in = 16'h0123; dp_in = 4'b0000;
                total++; if (an_a !== 4'hB) begin bad++; $display("FAIL mid_align_an got=%h exp=b", an_a); end
            end
            if (k >= 19 && an_a === 4'hB) begin
                total++; if (seg_a !== 7'h40) begin bad++; $display("FAIL mid_old_d2[%0d] got=%h exp=40", k, seg_a); end
            end
            if (k >= 19 && an_a === 4'h7) begin
                total++; if (seg_a !== 7'h3F) begin bad++; $display("FAIL mid_old_d3[%0d] got=%h exp=3f", k, seg_a); end
            end
            if (k == 32) begin
                total++; if (tick_a !== 1'b1) begin bad++; $display("FAIL mid_frame_end_tick got=%b exp=1", tick_a); end
            end
        end
        capture();
        total++; if (!cap_ok) begin bad++; $display("FAIL mid_next_tick got=timeout exp=tick"); end
        for (int d = 0; d < 4; d++) begin
            total++; if (cap_seg_a[d] !== ea[d]) begin bad++; $display("FAIL mid_new_seg[%0d] got=%h exp=%h", d, cap_seg_a[d], ea[d]); end
        end
    endtask

    // Display holds 0123; load 0007 exactly on the commit edge
    task automatic test_commit_load();
        logic [6:0] ea [4] = '{7'h78, 7'h7F, 7'h7F, 7'h7F};
        logic [6:0] eb [4] = '{7'h78, 7'h40, 7'h40, 7'h40};
        bit ok;
        int w;
        wait_tick(ok, w);
        total++; if (!ok) begin bad++; $display("FAIL cl_tick got=timeout exp=tick"); end
        for (int k = 1; k <= 31; k++) @(negedge clk);
        digits_in = 16'h0007; dp_in = 4'b0000; load = 1'b1;
        capture();
        total++; if (cap_wait != 1) begin bad++; $display("FAIL cl_tick_delay got=%0d exp=1", cap_wait); end
        for (int d = 0; d < 4; d++) begin
            total++; if (cap_seg_a[d] !== ea[d]) begin bad++; $display("FAIL cl_seg_a[%0d] got=%h exp=%h", d, cap_seg_a[d], ea[d]); end
            total++; if (cap_seg_b[d] !== eb[d]) begin bad++; $display("FAIL cl_seg_b[%0d] got=%h exp=%h", d, cap_seg_b[d], eb[d]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ea [4] = '{7'h24, 7'h19, 7'h7F, 7'h7F};
        logic [6:0] eb [4] = '{7'h24, 7'h19, 7'h40, 7'h40};
        digits_in = 16'h1111; dp_in = 4'b1111; load = 1'b1;
        @(negedge clk);
        digits_in = 16'h0042; dp_in = 4'b0000; load = 1'b1;
        capture();
        total++; if (!cap_ok) begin bad++; $display("FAIL b2b_tick got=timeout exp=tick"); end
        for (int d = 0; d < 4; d++) begin
            total++; if (cap_seg_a[d] !== ea[d]) begin bad++; $display("FAIL b2b_seg_a[%0d] got=%h exp=%h", d, cap_seg_a[d], ea[d]); end
            total++; if (cap_seg_b[d] !== eb[d]) begin bad++; $display("FAIL b2b_seg_b[%0d] got=%h exp=%h", d, cap_seg_b[d], eb[d]); end
            total++; if (cap_dp_a[d] !== 1'b1) begin bad++; $display("FAIL b2b_dp[%0d] got=%b exp=1", d, cap_dp_a[d]); end
        end
    endtask

    // Reset while digit 0 of 0042 is showing
    task automatic test_reset_mid();
        logic [3:0] exp_an;
        for (int k = 1; k <= 3; k++) @(negedge clk);
        total++; if (an_a !== 4'hE) begin bad++; $display("FAIL rmid_pre_an got=%h exp=e", an_a); end
        total++; if (seg_a !== 7'h24) begin bad++; $display("FAIL rmid_pre_seg got=%h exp=24", seg_a); end
        rst = 1'b1;
        #1;
        total++; if (seg_a !== 7'h7F) begin bad++; $display("FAIL rmid_seg got=%h exp=7f", seg_a); end
        total++; if (an_a !== 4'hF) begin bad++; $display("FAIL rmid_an got=%h exp=f", an_a); end
        total++; if (dp_a !== 1'b1) begin bad++; $display("FAIL rmid_dp got=%b exp=1", dp_a); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_an = (k <= 2) ? 4'hF : 4'hE;
            total++;
            if (an_a !== exp_an) begin bad++; $display("FAIL rmid_release_an[%0d] got=%h exp=%h", k, an_a, exp_an); end
        end
        capture();
        total++; if (!cap_ok) begin bad++; $display("FAIL rmid_tick got=timeout exp=tick"); end
        for (int d = 0; d < 4; d++) begin
            total++; if (cap_seg_b[d] !== 7'h7F) begin bad++; $display("FAIL rmid_cleared_seg[%0d] got=%h exp=7f", d, cap_seg_b[d]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dp_zero();
        test_minus();
        test_midframe_load();
        test_commit_load();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
